// File: rtl/bounds_table_dlk_if.sv
// Bus bundle between the load-unit/decoder side and the buffer-bounds table.
// The master side issues insert/remove/check/clear; the slave side returns results and status.
interface bounds_table_dlk_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              clear_i;
    logic              insert_valid_i;
    logic [ADDR_W-1:0] insert_addr_i;
    logic              remove_valid_i;
    logic [ADDR_W-1:0] remove_addr_i;
    logic              check_valid_i;
    logic [ADDR_W-1:0] check_base_i;
    logic [ADDR_W-1:0] check_addr_i;

    logic              check_valid_o;
    logic              check_overflow_o;
    logic              check_hit_o;
    logic [ADDR_W-1:0] check_limit_o;
    logic [IDX_W:0]    count_o;
    logic              full_o;
    logic              evict_o;

    modport master (
        output clear_i, insert_valid_i, insert_addr_i, remove_valid_i, remove_addr_i,
               check_valid_i, check_base_i, check_addr_i,
        input  check_valid_o, check_overflow_o, check_hit_o, check_limit_o,
               count_o, full_o, evict_o
    );

    modport slave (
        input  clear_i, insert_valid_i, insert_addr_i, remove_valid_i, remove_addr_i,
               check_valid_i, check_base_i, check_addr_i,
        output check_valid_o, check_overflow_o, check_hit_o, check_limit_o,
               count_o, full_o, evict_o
    );
endinterface

// File: rtl/bounds_table_dlk.sv
// Buffer-bounds table: records buffer base addresses and reports, one cycle later,
// the next recorded base above an access's buffer and whether the access crossed it.
module bounds_table_dlk #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bounds_table_dlk_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [ADDR_W-1:0] addr_t;

    addr_t            entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W-1:0] victim_q, victim_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             evict_q, evict_d;

    logic             chk_valid_q, chk_ovf_q, chk_hit_q;
    addr_t            chk_limit_q;
    logic             chk_ovf_d, chk_hit_d;
    addr_t            chk_limit_d;

    logic [DEPTH-1:0] ins_match, rem_match;
    logic             ins_dup, rem_en, wr_en, free_found;
    logic [IDX_W-1:0] free_idx, wr_idx;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ins_match  = '0;
        rem_match  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ins_match[i] = valid_q[i] && (entry_q[i] == bus.insert_addr_i);
            rem_match[i] = valid_q[i] && (entry_q[i] == bus.remove_addr_i);
        end
        // Scan downwards so the last hit is the lowest free index.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        ins_dup = |ins_match;
        // Insert and remove of the same address nets out to "entry present".
        rem_en  = bus.remove_valid_i &&
                  !(bus.insert_valid_i && (bus.insert_addr_i == bus.remove_addr_i));
        wr_en   = bus.insert_valid_i && !ins_dup && !bus.clear_i;
        wr_idx  = free_found ? free_idx : victim_q;

        valid_d  = valid_q;
        victim_d = victim_q;
        evict_d  = 1'b0;
        if (bus.clear_i) begin
            valid_d  = '0;
            victim_d = '0;
        end else begin
            if (rem_en) valid_d = valid_d & ~rem_match;
            if (wr_en) begin
                valid_d[wr_idx] = 1'b1;
                if (!free_found) begin
                    evict_d  = 1'b1;
                    victim_d = (victim_q == IDX_W'(DEPTH - 1)) ? '0 : victim_q + IDX_W'(1);
                end
            end
        end

        count_d = '0;
        for (int i = 0; i < DEPTH; i++) count_d = count_d + (IDX_W + 1)'(valid_d[i]);
    end

    // Smallest valid entry strictly above the checked base, on the pre-edge table.
    always_comb begin
        chk_hit_d   = 1'b0;
        chk_limit_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i] > bus.check_base_i) &&
                (!chk_hit_d || (entry_q[i] < chk_limit_d))) begin
                chk_hit_d   = 1'b1;
                chk_limit_d = entry_q[i];
            end
        end
        chk_ovf_d = chk_hit_d && (bus.check_addr_i >= chk_limit_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            victim_q    <= '0;
            count_q     <= '0;
            evict_q     <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_ovf_q   <= 1'b0;
            chk_hit_q   <= 1'b0;
            chk_limit_q <= '0;
        end else begin
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            count_q     <= count_d;
            evict_q     <= evict_d;
            chk_valid_q <= bus.check_valid_i;
            if (bus.check_valid_i) begin
                chk_ovf_q   <= chk_ovf_d;
                chk_hit_q   <= chk_hit_d;
                chk_limit_q <= chk_limit_d;
            end
        end
    end

    // NOTE: the address array is not reset; an entry is only ever read through its valid bit.
    always_ff @(posedge clk_i) begin
        if (wr_en) entry_q[wr_idx] <= bus.insert_addr_i;
    end

    assign bus.check_valid_o    = chk_valid_q;
    assign bus.check_overflow_o = chk_ovf_q;
    assign bus.check_hit_o      = chk_hit_q;
    assign bus.check_limit_o    = chk_limit_q;
    assign bus.count_o          = count_q;
    assign bus.full_o           = (count_q == (IDX_W + 1)'(DEPTH));
    assign bus.evict_o          = evict_q;
endmodule

// File: doc/bounds_table_dlk.md
Name: bounds_table_dlk

Overview:
- Parametrised buffer-bounds table for load overflow detection. It records buffer base addresses and answers, one cycle later, whether an access has crossed into the next recorded buffer.
- Adds the following over the first-generation circular buffer:
  - per-entry valid bits and explicit removal;
  - free-slot reuse, with round-robin eviction when full;
  - a registered check pipeline.
- Sits beside the load unit; the decoder drives insert/remove from custom instructions.

Parameters:
- ADDR_W, 32, width of base and access addresses.
- DEPTH, 32, number of table entries; any value >= 2.
- IDX_W, $clog2(DEPTH), derived localparam; pointer width. Not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous table flush (debug instruction).
- insert_valid_i  in  1  record insert_addr_i this cycle.
- insert_addr_i  in  ADDR_W  base address to record.
- remove_valid_i  in  1  invalidate entry equal to remove_addr_i.
- remove_addr_i  in  ADDR_W  base address to drop.
- check_valid_i  in  1  issue a bounds check.
- check_base_i  in  ADDR_W  base of the buffer being accessed.
- check_addr_i  in  ADDR_W  effective access address.
- check_valid_o  out  1  result valid, one cycle after check_valid_i.
- check_overflow_o  out  1  access crossed the next recorded base.
- check_hit_o  out  1  a higher recorded base exists.
- check_limit_o  out  ADDR_W  that higher base; 0 when check_hit_o=0.
- count_o  out  IDX_W+1  number of valid entries.
- full_o  out  1  count_o == DEPTH.
- evict_o  out  1  one-cycle pulse: an insert overwrote a valid entry.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - all valid bits are 0; victim pointer is 0.
  - count_o=0, full_o=0, evict_o=0.
  - check_valid_o=0, check_overflow_o=0, check_hit_o=0, check_limit_o=0.
  - The design comes out of reset on the first clock edge after deassertion.
- clear_i=1 at a clock edge:
  - same table state as reset (valids, pointer, count cleared); insert/remove that cycle are ignored.
  - A check issued that cycle still produces its result next cycle, computed on the pre-clear table.
- Insert:
  - Duplicate (insert_addr_i equals any valid entry): no state change, evict_o=0.
  - Free slot exists (pre-edge state): write to the lowest-index invalid entry, set its valid bit, count +1.
  - Table full: overwrite the entry at the victim pointer and pulse evict_o the next cycle. The victim pointer advances mod DEPTH (DEPTH-1 -> 0). Count is unchanged.
  - Address 0 is an ordinary value.
- Remove:
  - Clears the valid bit of the matching entry and decrements count.
  - No match: no-op.
  - The victim pointer is not moved by removes.
- Simultaneous insert and remove:
  - Equal addresses: the net result is the entry valid. If it was already present, count is unchanged; otherwise it is inserted as above.
  - Different addresses: both apply. The insert slot is chosen from the pre-edge free vector, so a slot freed this cycle is not reused until the next cycle. Count = old + inserted - removed.
- Check (latency 1, fully pipelined, one check per cycle):
  - Computed on the table state before the same edge's insert/remove/clear.
  - limit = minimum valid entry strictly greater than check_base_i, using unsigned compare.
  - hit = at least one such entry exists.
  - overflow = hit AND (check_addr_i >= limit), unsigned.
  - If hit=0: overflow=0 and limit output=0.
  - Outputs are registered and update only when check_valid_i=1. check_valid_o follows check_valid_i by one cycle. Other result outputs hold their last value while check_valid_o=0.
- Comparisons are combinational over all DEPTH entries. No addition is performed, so there is no wrap arithmetic.

Test Plan:
- Reset, then insert 0x1000, 0x2000, 0x3000; check base=0x1000 addr=0x1FFC -> next cycle check_valid_o=1, hit=1, limit=0x2000, overflow=0; count_o=3.
- Same table; check base=0x1000 addr=0x2000 -> overflow=1. Check base=0x3000 addr=0xFFFF0000 -> hit=0, limit=0, overflow=0.
- Insert 0x2000 twice -> count_o unchanged, evict_o=0. Remove 0x2000, then check base=0x1000 addr=0x2800 -> limit=0x3000, overflow=0; count_o=2.
- Fill DEPTH=4 instance with A,B,C,D; insert E -> entry 0 (A) replaced, evict_o pulses once, full_o=1. Insert F -> entry 1 replaced. Remove C, insert G -> G written at slot 2, no evict.
- Same-cycle insert X, remove Y (Y valid, table full) -> X evicts the victim, not Y's slot. count_o = DEPTH-1 next cycle.
- Back-to-back checks over 3 cycles with insert of the limit address in cycle 1 -> cycle-1 result excludes it, cycle-2 result includes it. rst_i pulsed mid-stream -> all outputs 0 immediately, table empty.
